rs_ff_bank_ctrl: RTL

Sequencer and arbiter for a bank of N_FF clocked RS flip-flops (rs_ff instances: clk, r, s, q, nq). Two requesters issue set/reset commands through valid/ready handshakes. The block grants them round-robin, drives exactly one r or s line for a fixed pulse width, reads back q, and reports done/error. It sits between the control logic and the flip-flop bank. It guarantees the forbidden r=s=1 input is never applied.

---
 rtl/rs_ff_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 38 +++
 rtl/rs_ff_bank_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rs_ff_ctrl_pkg.sv
// Shared encodings for the RS flip-flop bank controller and its arbiter.
package rs_ff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam logic OP_RESET = 1'b0;
    localparam logic OP_SET   = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on a tie the requester not granted last wins.
module rr_arb2
    import rs_ff_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b,
    output logic update
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant decision is purely combinational so ready can be returned in the same cycle.
    always_comb begin
        grant_a      = en & req_a & (~req_b | (last_grant_q == SRC_B));
        grant_b      = en & req_b & (~req_a | (last_grant_q == SRC_A));
        update       = grant_a | grant_b;
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = grant_b ? SRC_B : SRC_A;
        end
    end

    // Reset to B so that A wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= SRC_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/rs_ff_bank_ctrl.sv
// Sequencer for a bank of clocked RS flip-flops: arbitrates two requesters,
// drives one r or s line for a fixed pulse, then checks the readback.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for a request; grant cycle captures idx/op/src
// ST_PULSE  | one r or s line high for PULSE_CYCLES cycles
// ST_SETTLE | all lines low; flip-flop q settles on this clock edge
// ST_CHECK  | cmd_done pulse with readback/bad-index error
module rs_ff_bank_ctrl
    import rs_ff_ctrl_pkg::*;
#(
    parameter int N_FF         = 4,
    parameter int IDX_W        = 2,
    parameter int PULSE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             a_op,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [IDX_W-1:0] b_idx,
    input  logic             b_op,
    output logic [N_FF-1:0]  ff_r,
    output logic [N_FF-1:0]  ff_s,
    input  logic [N_FF-1:0]  ff_q,
    output logic             cmd_done,
    output logic             cmd_err,
    output logic             cmd_src
);

    localparam int NSEL  = 2 ** IDX_W;
    localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [IDX_W:0] N_FF_L = (IDX_W + 1)'(N_FF);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_q, op_d;
    logic               src_q, src_d;
    logic               bad_q, bad_d;
    logic [N_FF-1:0]    ff_r_q, ff_r_d;
    logic [N_FF-1:0]    ff_s_q, ff_s_d;

    logic               grant_a, grant_b, grant_upd;
    logic [IDX_W-1:0]   req_idx;
    logic               req_op;
    logic               req_bad;
    logic               pulse_en;
    logic [IDX_W-1:0]   pulse_idx;
    logic               pulse_op;
    logic [NSEL-1:0]    pulse_sel;
    logic [NSEL-1:0]    q_pad;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_IDLE),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .grant_a (grant_a),
        .grant_b (grant_b),
        .update  (grant_upd)
    );

    assign a_ready = grant_a;
    assign b_ready = grant_b;
    assign ff_r    = ff_r_q;
    assign ff_s    = ff_s_q;

    // Next-state, capture and next value of the registered r/s lines.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        op_d      = op_q;
        src_d     = src_q;
        bad_d     = bad_q;
        pulse_en  = 1'b0;
        pulse_idx = idx_q;
        pulse_op  = op_q;
        req_idx   = grant_b ? b_idx : a_idx;
        req_op    = grant_b ? b_op  : a_op;
        req_bad   = ({1'b0, req_idx} >= N_FF_L);

        case (state_q)
            ST_IDLE: begin
                if (grant_upd) begin
                    idx_d = req_idx;
                    op_d  = req_op;
                    src_d = grant_b ? SRC_B : SRC_A;
                    bad_d = req_bad;
                    cnt_d = CNT_W'(PULSE_CYCLES - 1);
                    if (req_bad) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d   = ST_PULSE;
                        pulse_en  = 1'b1;
                        pulse_idx = req_idx;
                        pulse_op  = req_op;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d    = cnt_q - CNT_W'(1);
                    pulse_en = 1'b1;
                end
            end
            ST_SETTLE: state_d = ST_CHECK;
            ST_CHECK: begin
                state_d = ST_IDLE;
                bad_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // One-hot select is built at full index width so out-of-range indices never alias a real line.
        pulse_sel            = '0;
        pulse_sel[pulse_idx] = pulse_en;
        ff_s_d = (pulse_op == OP_SET)   ? pulse_sel[N_FF-1:0] : '0;
        ff_r_d = (pulse_op == OP_RESET) ? pulse_sel[N_FF-1:0] : '0;
    end

    // Completion reporting; err/src are gated so they read 0 outside cmd_done.
    always_comb begin
        q_pad           = '0;
        q_pad[N_FF-1:0] = ff_q;
        cmd_done        = (state_q == ST_CHECK);
        cmd_err         = cmd_done & (bad_q | (q_pad[idx_q] != op_q));
        cmd_src         = cmd_done & src_q;
    end

    // State, capture registers and r/s lines; reset drops any in-flight pulse at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            src_q   <= 1'b0;
            bad_q   <= 1'b0;
            ff_r_q  <= '0;
            ff_s_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            src_q   <= src_d;
            bad_q   <= bad_d;
            ff_r_q  <= ff_r_d;
            ff_s_q  <= ff_s_d;
        end
    end

endmodule
